// File: rtl/bcd_time_counter.sv
// MM:SS BCD time counter with a 1 Hz prescaler, up/down counting, clamped load
// and one-cycle tick/wrap pulses aligned with the new digit values.
module bcd_time_counter #(
    parameter int TICK_DIV     = 50000000,
    parameter bit STOP_AT_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       count_down,
    input  logic       load,
    input  logic [3:0] ld_d0,
    input  logic [3:0] ld_d1,
    input  logic [3:0] ld_d2,
    input  logic [3:0] ld_d3,
    output logic [3:0] current0,
    output logic [3:0] current1,
    output logic [3:0] current2,
    output logic [3:0] current3,
    output logic       sec_tick,
    output logic       wrap,
    output logic       at_zero
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic [3:0]    d0, d1, d2, d3;
    logic [3:0]    n0, n1, n2, n3;
    logic          n_wrap;
    logic          tick;
    logic          is_zero;

    function automatic logic [3:0] clamp_units(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    function automatic logic [3:0] clamp_tens(input logic [3:0] v);
        return (v > 4'd5) ? 4'd5 : v;
    endfunction

    assign is_zero  = (d0 == 4'd0) && (d1 == 4'd0) && (d2 == 4'd0) && (d3 == 4'd0);
    assign tick     = run && (presc == PRESC_TOP);
    assign at_zero  = is_zero;
    assign current0 = d0;
    assign current1 = d1;
    assign current2 = d2;
    assign current3 = d3;

    // Next-digit carry/borrow chain; only consumed on a tick edge.
    always_comb begin
        n0     = d0;
        n1     = d1;
        n2     = d2;
        n3     = d3;
        n_wrap = 1'b0;
        if (!count_down) begin
            if (d0 == 4'd9) begin
                n0 = 4'd0;
                if (d1 == 4'd5) begin
                    n1 = 4'd0;
                    if (d2 == 4'd9) begin
                        n2 = 4'd0;
                        if (d3 == 4'd5) begin
                            n3     = 4'd0;
                            n_wrap = 1'b1;
                        end else begin
                            n3 = d3 + 4'd1;
                        end
                    end else begin
                        n2 = d2 + 4'd1;
                    end
                end else begin
                    n1 = d1 + 4'd1;
                end
            end else begin
                n0 = d0 + 4'd1;
            end
        end else if (!(is_zero && STOP_AT_ZERO)) begin
            // Countdown: at 00:00 this either holds (above) or rolls to 59:59.
            n_wrap = is_zero;
            if (d0 == 4'd0) begin
                n0 = 4'd9;
                if (d1 == 4'd0) begin
                    n1 = 4'd5;
                    if (d2 == 4'd0) begin
                        n2 = 4'd9;
                        n3 = (d3 == 4'd0) ? 4'd5 : d3 - 4'd1;
                    end else begin
                        n2 = d2 - 4'd1;
                    end
                end else begin
                    n1 = d1 - 4'd1;
                end
            end else begin
                n0 = d0 - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc    <= '0;
            d0       <= 4'd0;
            d1       <= 4'd0;
            d2       <= 4'd0;
            d3       <= 4'd0;
            sec_tick <= 1'b0;
            wrap     <= 1'b0;
        end else if (load) begin
            // A load on a tick edge discards that tick.
            presc    <= '0;
            d0       <= clamp_units(ld_d0);
            d1       <= clamp_tens(ld_d1);
            d2       <= clamp_units(ld_d2);
            d3       <= clamp_tens(ld_d3);
            sec_tick <= 1'b0;
            wrap     <= 1'b0;
        end else if (tick) begin
            presc    <= '0;
            d0       <= n0;
            d1       <= n1;
            d2       <= n2;
            d3       <= n3;
            sec_tick <= 1'b1;
            wrap     <= n_wrap;
        end else begin
            if (run) begin
                presc <= presc + PW'(1);
            end
            sec_tick <= 1'b0;
            wrap     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter: two instances (hold-at-zero and wrap-at-zero)
// share stimulus; expected tick results are queued at stimulus time and popped per tick.
module tb_bcd_time_counter;

    logic       clk = 1'b0;
    logic       reset, run, count_down, load;
    logic [3:0] ld_d0, ld_d1, ld_d2, ld_d3;

    logic [3:0] a_c0, a_c1, a_c2, a_c3;
    logic       a_tick, a_wrap, a_zero;
    logic [3:0] b_c0, b_c1, b_c2, b_c3;
    logic       b_tick, b_wrap, b_zero;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       tag;
        logic [15:0] da;
        logic        wa;
        logic [15:0] db;
        logic        wb;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_time_counter #(.TICK_DIV(4), .STOP_AT_ZERO(1'b1)) dut_a (
        .clk(clk), .reset(reset), .run(run), .count_down(count_down), .load(load),
        .ld_d0(ld_d0), .ld_d1(ld_d1), .ld_d2(ld_d2), .ld_d3(ld_d3),
        .current0(a_c0), .current1(a_c1), .current2(a_c2), .current3(a_c3),
        .sec_tick(a_tick), .wrap(a_wrap), .at_zero(a_zero)
    );

    bcd_time_counter #(.TICK_DIV(4), .STOP_AT_ZERO(1'b0)) dut_b (
        .clk(clk), .reset(reset), .run(run), .count_down(count_down), .load(load),
        .ld_d0(ld_d0), .ld_d1(ld_d1), .ld_d2(ld_d2), .ld_d3(ld_d3),
        .current0(b_c0), .current1(b_c1), .current2(b_c2), .current3(b_c3),
        .sec_tick(b_tick), .wrap(b_wrap), .at_zero(b_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    task automatic push(input string tag, input logic [15:0] da, input logic wa,
                        input logic [15:0] db, input logic wb);
        exp_t e;
        e.tag = tag; e.da = da; e.wa = wa; e.db = db; e.wb = wb;
        sb.push_back(e);
    endtask

    task automatic do_load(input logic [3:0] v3, input logic [3:0] v2,
                           input logic [3:0] v1, input logic [3:0] v0);
        ld_d3 = v3; ld_d2 = v2; ld_d1 = v1; ld_d0 = v0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Waits for the next tick, then pops and compares one scoreboard entry.
    task automatic wait_tick(output int n);
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_tick && n < 20);
        if (!a_tick) begin
            chk("tick_timeout", 32'(a_tick), 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_a_digits"}, 32'({a_c3, a_c2, a_c1, a_c0}), 32'(e.da));
            chk({e.tag, "_a_wrap"}, 32'(a_wrap), 32'(e.wa));
            chk({e.tag, "_a_zero"}, 32'(a_zero), 32'(e.da == 16'h0000));
            chk({e.tag, "_b_tick"}, 32'(b_tick), 32'd1);
            chk({e.tag, "_b_digits"}, 32'({b_c3, b_c2, b_c1, b_c0}), 32'(e.db));
            chk({e.tag, "_b_wrap"}, 32'(b_wrap), 32'(e.wb));
        end
    endtask

    initial begin
        int n;
        logic [15:0] v;
        reset = 1'b1; run = 1'b0; count_down = 1'b0; load = 1'b0;
        ld_d0 = 4'd0; ld_d1 = 4'd0; ld_d2 = 4'd0; ld_d3 = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_digits", 32'({a_c3, a_c2, a_c1, a_c0}), 32'h0);
        chk("rst_tick", 32'(a_tick), 32'd0);
        chk("rst_wrap", 32'(a_wrap), 32'd0);
        chk("rst_zero", 32'(a_zero), 32'd1);

        // Count up from 00:00 for ten ticks.
        for (int k = 1; k <= 10; k++) begin
            v = (k == 10) ? 16'h0010 : 16'(k);
            push($sformatf("up%0d", k), v, 1'b0, v, 1'b0);
        end
        run = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            wait_tick(n);
            chk($sformatf("up_period%0d", k), 32'(n), 32'd4);
        end

        // Up wrap 59:58 -> 59:59 -> 00:00.
        do_load(4'd5, 4'd9, 4'd5, 4'd8);
        chk("ld5958", 32'({a_c3, a_c2, a_c1, a_c0}), 32'h5958);
        push("upw1", 16'h5959, 1'b0, 16'h5959, 1'b0);
        push("upw2", 16'h0000, 1'b1, 16'h0000, 1'b1);
        wait_tick(n);
        chk("upw_period", 32'(n), 32'd4);
        wait_tick(n);
        @(negedge clk);
        chk("upw_wrap_once", 32'(a_wrap), 32'd0);
        chk("upw_zero_after", 32'(a_zero), 32'd1);

        // Countdown from 00:02: dut_a holds at zero, dut_b rolls over.
        count_down = 1'b1;
        do_load(4'd0, 4'd0, 4'd0, 4'd2);
        push("dn1", 16'h0001, 1'b0, 16'h0001, 1'b0);
        push("dn2", 16'h0000, 1'b0, 16'h0000, 1'b0);
        push("dn3", 16'h0000, 1'b0, 16'h5959, 1'b1);
        push("dn4", 16'h0000, 1'b0, 16'h5958, 1'b0);
        repeat (4) wait_tick(n);

        // Borrow through every digit.
        do_load(4'd1, 4'd0, 4'd0, 4'd0);
        push("borrow", 16'h0959, 1'b0, 16'h0959, 1'b0);
        wait_tick(n);

        // Clamped load landing exactly on a tick edge.
        repeat (3) @(negedge clk);
        do_load(4'd7, 4'd12, 4'd6, 4'd15);
        chk("clamp_digits", 32'({a_c3, a_c2, a_c1, a_c0}), 32'h5959);
        chk("clamp_no_tick", 32'(a_tick), 32'd0);
        chk("clamp_no_wrap", 32'(b_wrap), 32'd0);
        push("after_clamp", 16'h5958, 1'b0, 16'h5958, 1'b0);
        wait_tick(n);
        chk("after_clamp_period", 32'(n), 32'd4);

        // Pause after two prescaler cycles; the partial second resumes.
        count_down = 1'b0;
        repeat (2) @(negedge clk);
        run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("pause_tick%0d", k), 32'(a_tick), 32'd0);
        end
        chk("pause_digits", 32'({a_c3, a_c2, a_c1, a_c0}), 32'h5958);
        push("resume", 16'h5959, 1'b0, 16'h5959, 1'b0);
        run = 1'b1;
        wait_tick(n);
        chk("resume_period", 32'(n), 32'd2);

        // Reset mid-second, then reset together with a load.
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_digits", 32'({a_c3, a_c2, a_c1, a_c0}), 32'h0);
        chk("midrst_tick", 32'(a_tick), 32'd0);
        chk("midrst_zero", 32'(a_zero), 32'd1);
        reset = 1'b1;
        do_load(4'd5, 4'd9, 4'd5, 4'd9);
        reset = 1'b0;
        chk("rstload_digits", 32'({b_c3, b_c2, b_c1, b_c0}), 32'h0);
        chk("rstload_tick", 32'(b_tick), 32'd0);
        push("post_rst", 16'h0001, 1'b0, 16'h0001, 1'b0);
        wait_tick(n);
        chk("post_rst_period", 32'(n), 32'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
